uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Sequences uart_receive and buffers its bytes for the host.
//  - Captures each received byte into a local FIFO.
//  - Releases the receiver from its post-batch hold via a one-cycle rx_finish pulse, issued only when FIFO space exists.
//  - Counts frame errors and dropped bytes; raises a level-threshold interrupt.
//  - Sits between uart_receive and the Wishbone/AXI-lite register shim.
// PARAMETERS
//  FIFO_DEPTH  16  local byte FIFO entries; power of 2, >=4
//  CNT_W       16  width of the error/drop counters; counters saturate
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        async active-low reset
//  enable       in   1        0: bytes ignored, rx_finish is still served
//  flush        in   1        1-cycle pulse: empty FIFO, clear counters
//  rx_data      in   8        byte from uart_receive
//  irq          in   1        batch-end byte strobe; receiver then holds
//  fake_irq     in   1        ordinary byte strobe; receiver continues
//  frame_err    in   1        stop-bit error strobe from the receiver
//  busy         in   1        receiver mid-frame
//  rx_finish    out  1        1-cycle pulse releasing the receiver hold
//  rd_data      out  8        FIFO head byte
//  rd_valid     out  1        FIFO not empty
//  rd_ready     in   1        host pop; a pop occurs when rd_valid&rd_ready
//  level        out  $clog2(FIFO_DEPTH)+1   FIFO occupancy
//  thr          in   $clog2(FIFO_DEPTH)+1   interrupt threshold; 0 disables it
//  int_o        out  1        sticky interrupt
//  int_clr      in   1        1-cycle pulse clearing int_o
//  ferr_cnt     out  CNT_W    frame errors seen
//  drop_cnt     out  CNT_W    bytes dropped (FIFO full or held)
//  rx_active    out  1        busy | (state!=IDLE)
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; state IDLE; counters 0.
//  Byte strobe: stb = irq|fake_irq. rx_data is valid only in the stb cycle; sample it then.
//  Push: on stb & enable. Push if the FIFO is not full, else drop_cnt++.
//    A full FIFO never blocks the receiver; the byte is lost.
//  Simultaneous push and pop when full: allowed; level stays unchanged.
//  Simultaneous push and pop when empty: byte lands in FIFO; rd_valid rises the next cycle.
//  rd_data is registered at the FIFO head. Zero-latency show-ahead.
//  frame_err strobe: ferr_cnt++ and no push. frame_err never coincides with stb.
//  FSM:
//    IDLE: irq -> HOLD (after the push decision above).
//    HOLD: receiver is parked in its read-wait state.
//      level < FIFO_DEPTH -> REL, so space exists for the next byte.
//      enable=0 -> REL immediately.
//    REL: rx_finish=1 for exactly 1 cycle -> IDLE.
//  rx_finish is asserted only in REL; never two consecutive cycles.
//  irq while in HOLD or REL is illegal (the receiver cannot produce it). Treat it as a drop.
//  Interrupt: int_o sets when thr!=0 and level>=thr.
//    It stays set until int_clr. If int_clr and the set condition hold in the same cycle, set wins.
//  flush: FIFO, level and counters -> 0 next cycle. FSM is unaffected.
//    A push in the flush cycle is discarded and not counted.
//  Counters saturate at all-ones.
//  Reset mid-HOLD: FSM returns to IDLE and no rx_finish is issued.
//    The receiver shares rst_n, so both recover together.
// STRUCTURE
//  uart_pkg: FSM encodings IDLE/HOLD/REL as localparams, BYTE_W=8.
//  Sub-module uart_rx_fifo: sync FIFO with show-ahead.
//    Has DEPTH param, wr_en/rd_en/full/empty/level; flush input.
//  Top level holds the FSM, counters and interrupt logic only.
// TESTING
//  1. 3 fake_irq strobes (0x11,0x22,0x33), rd_ready=1 -> rd_data 11,22,33 in order; level returns to 0.
//  2. irq strobe with FIFO at level 5/16 -> exactly one rx_finish pulse 2 cycles after stb; state returns to IDLE.
//  3. Fill 16 bytes, rd_ready=0, 17th irq strobe -> drop_cnt=1; rx_finish withheld until one pop, then pulses once.
//  4. thr=4, push 4 bytes -> int_o=1 after 4th push; int_clr at level 4 -> stays 1; pop one, int_clr -> 0.
//  5. 3 frame_err strobes, plus a flush during a concurrent stb -> ferr_cnt 3 then 0; level 0; no drop counted.
//  6. Assert rst_n=0 while in HOLD -> all outputs 0 at once; no rx_finish after release; next irq handled normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared byte width and receive-sequencer state encodings.
package uart_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] ENC_IDLE = 2'd0;
    localparam logic [1:0] ENC_HOLD = 2'd1;
    localparam logic [1:0] ENC_REL  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ENC_IDLE,
        HOLD = ENC_HOLD,
        REL  = ENC_REL
    } rx_state_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receiver-facing strobes plus host-facing show-ahead read port.
interface uart_rx_ctrl_if;
    import uart_pkg::*;

    logic [BYTE_W-1:0] rx_data;
    logic              irq;
    logic              fake_irq;
    logic              frame_err;
    logic              busy;
    logic              rx_finish;
    logic [BYTE_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;

    modport master (
        input  rx_data, irq, fake_irq, frame_err, busy, rd_ready,
        output rx_finish, rd_data, rd_valid
    );

    modport slave (
        output rx_data, irq, fake_irq, frame_err, busy, rd_ready,
        input  rx_finish, rd_data, rd_valid
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Sync byte FIFO, show-ahead head (0-cycle read), push visible next cycle.
// Push accepted when full only alongside a pop; flush empties it next cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = BYTE_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [W-1:0]           wr_data,
    input  logic                   rd_en,
    output logic [W-1:0]           rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          rd_ok;
    logic          wr_ok;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_ok   = rd_en & ~empty & ~flush;
    assign wr_ok   = wr_en & (~full | rd_ok) & ~flush;
    // Gate the head so an empty FIFO never exposes stale storage.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// Buffers uart_receive bytes and releases its post-batch hold; rx_finish 2 cycles after irq when space exists.
// Never backpressures the receiver: bytes arriving on a full FIFO or while held are dropped and counted.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        flush,
    uart_rx_ctrl_if.master              bus,
    output logic [$clog2(FIFO_DEPTH):0] level,
    input  logic [$clog2(FIFO_DEPTH):0] thr,
    output logic                        int_o,
    input  logic                        int_clr,
    output logic [CNT_W-1:0]            ferr_cnt,
    output logic [CNT_W-1:0]            drop_cnt,
    output logic                        rx_active
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    rx_state_t state, state_nxt;
    logic      stb, pop, accept, can_push, wr_en, drop_inc, full, empty, int_set;

    assign stb      = bus.irq | bus.fake_irq;
    assign pop      = bus.rd_valid & bus.rd_ready;
    assign accept   = stb & enable & ~flush;
    // Only an idle receiver legitimately strobes; anything else is a lost byte.
    assign can_push = (state == IDLE) & (~full | pop);
    assign wr_en    = accept & can_push;
    assign drop_inc = accept & ~can_push;
    assign int_set  = (thr != '0) && (level >= thr);

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(BYTE_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .wr_en   (wr_en),
        .wr_data (bus.rx_data),
        .rd_en   (bus.rd_ready),
        .rd_data (bus.rd_data),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    assign bus.rd_valid  = ~empty;
    assign bus.rx_finish = (state == REL);
    assign rx_active     = bus.busy | (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.irq) state_nxt = HOLD;
            HOLD:    if (!enable || level < LW'(FIFO_DEPTH)) state_nxt = REL;
            REL:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ferr_cnt <= '0;
            drop_cnt <= '0;
        end else if (flush) begin
            ferr_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (bus.frame_err && !(&ferr_cnt)) ferr_cnt <= ferr_cnt + 1'b1;
            if (drop_inc && !(&drop_cnt))      drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // Set has priority over clear so a still-valid condition is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) int_o <= 1'b0;
        else        int_o <= int_set | (int_o & ~int_clr);
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with hand-computed expectations.
module tb_uart_rx_ctrl;
    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        flush;
    logic [4:0]  level;
    logic [4:0]  thr;
    logic        int_o;
    logic        int_clr;
    logic [15:0] ferr_cnt;
    logic [15:0] drop_cnt;
    logic        rx_active;
    int          checks;
    int          failures;
    int          n;

    uart_rx_ctrl_if bus();

    uart_rx_ctrl #(.FIFO_DEPTH(16), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .flush     (flush),
        .bus       (bus),
        .level     (level),
        .thr       (thr),
        .int_o     (int_o),
        .int_clr   (int_clr),
        .ferr_cnt  (ferr_cnt),
        .drop_cnt  (drop_cnt),
        .rx_active (rx_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic is_irq);
        bus.rx_data  = b;
        bus.irq      = is_irq;
        bus.fake_irq = ~is_irq;
        tick();
        bus.irq      = 1'b0;
        bus.fake_irq = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; enable = 1'b0; flush = 1'b0; thr = 5'd0; int_clr = 1'b0;
        bus.rx_data = 8'h00; bus.irq = 1'b0; bus.fake_irq = 1'b0;
        bus.frame_err = 1'b0; bus.busy = 1'b0; bus.rd_ready = 1'b0;

        #12;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_data", 32'(bus.rd_data), 32'h00);
        chk("rst_rx_finish", 32'(bus.rx_finish), 32'd0);
        chk("rst_int", 32'(int_o), 32'd0);
        chk("rst_ferr", 32'(ferr_cnt), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_active", 32'(rx_active), 32'd0);
        rst_n = 1'b1; enable = 1'b1;
        tick();

        // In-order delivery through the show-ahead head
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
        chk("t1_level3", 32'(level), 32'd3);
        bus.rd_ready = 1'b1;
        chk("t1_head11", 32'(bus.rd_data), 32'h11);
        tick(); chk("t1_head22", 32'(bus.rd_data), 32'h22);
        tick(); chk("t1_head33", 32'(bus.rd_data), 32'h33);
        tick(); chk("t1_level0", 32'(level), 32'd0);
        chk("t1_valid0", 32'(bus.rd_valid), 32'd0);
        bus.rd_ready = 1'b0;

        // irq at level 5: single rx_finish two cycles after the strobe
        for (int i = 0; i < 5; i++) send(8'(8'h40 + i), 1'b0);
        chk("t2_level5", 32'(level), 32'd5);
        send(8'h55, 1'b1);
        chk("t2_hold_fin", 32'(bus.rx_finish), 32'd0);
        chk("t2_hold_act", 32'(rx_active), 32'd1);
        chk("t2_level6", 32'(level), 32'd6);
        tick(); chk("t2_rel_fin", 32'(bus.rx_finish), 32'd1);
        tick(); chk("t2_idle_fin", 32'(bus.rx_finish), 32'd0);
        chk("t2_idle_act", 32'(rx_active), 32'd0);
        chk("t2_head40", 32'(bus.rd_data), 32'h40);
        bus.rd_ready = 1'b1;
        repeat (6) tick();
        bus.rd_ready = 1'b0;
        chk("t2_drained", 32'(level), 32'd0);

        // Full FIFO: irq byte dropped, release withheld until a pop
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
        chk("t3_full", 32'(level), 32'd16);
        send(8'hAA, 1'b1);
        chk("t3_drop1", 32'(drop_cnt), 32'd1);
        chk("t3_level16", 32'(level), 32'd16);
        n = 32'(bus.rx_finish);
        repeat (3) begin tick(); n += 32'(bus.rx_finish); end
        chk("t3_withheld", 32'(n), 32'd0);
        bus.rd_ready = 1'b1; tick(); bus.rd_ready = 1'b0;
        chk("t3_level15", 32'(level), 32'd15);
        chk("t3_head01", 32'(bus.rd_data), 32'h01);
        n = 0;
        repeat (4) begin n += 32'(bus.rx_finish); tick(); end
        chk("t3_one_pulse", 32'(n), 32'd1);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t3_flush_level", 32'(level), 32'd0);
        chk("t3_flush_drop", 32'(drop_cnt), 32'd0);

        // Threshold interrupt: sticky, set beats clear
        thr = 5'd4;
        for (int i = 0; i < 4; i++) send(8'(8'h60 + i), 1'b0);
        chk("t4_level4", 32'(level), 32'd4);
        tick(); chk("t4_int_set", 32'(int_o), 32'd1);
        int_clr = 1'b1; tick(); int_clr = 1'b0;
        chk("t4_clr_held", 32'(int_o), 32'd1);
        bus.rd_ready = 1'b1; tick(); bus.rd_ready = 1'b0;
        chk("t4_level3", 32'(level), 32'd3);
        chk("t4_sticky", 32'(int_o), 32'd1);
        int_clr = 1'b1; tick(); int_clr = 1'b0;
        chk("t4_cleared", 32'(int_o), 32'd0);
        thr = 5'd0;
        flush = 1'b1; tick(); flush = 1'b0;

        // Frame errors counted; flush discards a coincident byte
        bus.frame_err = 1'b1; repeat (3) tick(); bus.frame_err = 1'b0;
        chk("t5_ferr3", 32'(ferr_cnt), 32'd3);
        chk("t5_nopush", 32'(level), 32'd0);
        flush = 1'b1; bus.fake_irq = 1'b1; bus.rx_data = 8'h77;
        tick();
        flush = 1'b0; bus.fake_irq = 1'b0; bus.rx_data = 8'h00;
        chk("t5_ferr0", 32'(ferr_cnt), 32'd0);
        chk("t5_level0", 32'(level), 32'd0);
        chk("t5_drop0", 32'(drop_cnt), 32'd0);
        tick(); chk("t5_still0", 32'(bus.rd_valid), 32'd0);

        // Disabled: bytes ignored, yet release still served
        enable = 1'b0;
        send(8'h99, 1'b0);
        chk("en0_level", 32'(level), 32'd0);
        chk("en0_drop", 32'(drop_cnt), 32'd0);
        send(8'h98, 1'b1);
        chk("en0_hold", 32'(rx_active), 32'd1);
        tick(); chk("en0_fin", 32'(bus.rx_finish), 32'd1);
        tick(); chk("en0_idle", 32'(bus.rx_finish), 32'd0);
        enable = 1'b1;

        // Reset while held
        for (int i = 0; i < 16; i++) send(8'(8'h80 + i), 1'b0);
        send(8'hBB, 1'b1);
        chk("t6_held", 32'(rx_active), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_level", 32'(level), 32'd0);
        chk("t6_rst_valid", 32'(bus.rd_valid), 32'd0);
        chk("t6_rst_drop", 32'(drop_cnt), 32'd0);
        chk("t6_rst_active", 32'(rx_active), 32'd0);
        chk("t6_rst_fin", 32'(bus.rx_finish), 32'd0);
        tick();
        #2 rst_n = 1'b1;
        n = 0;
        repeat (4) begin tick(); n += 32'(bus.rx_finish); end
        chk("t6_no_fin", 32'(n), 32'd0);
        send(8'h66, 1'b1);
        chk("t6_new_level", 32'(level), 32'd1);
        tick();
        chk("t6_new_fin", 32'(bus.rx_finish), 32'd1);
        chk("t6_new_head", 32'(bus.rd_data), 32'h66);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
